// File: rtl/dsp_mac_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dsp_mac_stream
// Brief    : Signed streaming pre-add/multiply/accumulate engine that emits one
//            result per frame over a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_stream #(
  parameter int AW      = 18,
  parameter int BW      = 18,
  parameter int PW      = 48,
  parameter int MREG    = 1,
  parameter int PRE_EN  = 1,
  parameter int SAT     = 1,
  parameter int MAX_LEN = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [AW-1:0]               in_a,
  input  logic signed [BW-1:0]               in_b,
  input  logic signed [BW-1:0]               in_d,
  input  logic                               in_pre_sub,
  input  logic                               in_acc_sub,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [PW-1:0]               out_p,
  output logic [$clog2(MAX_LEN+1)-1:0]       out_count,
  output logic                               out_ovf,
  output logic                               out_trunc
);

  localparam int                      c_MW      = AW + BW + 1;
  localparam int                      c_CW      = $clog2(MAX_LEN + 1);
  localparam logic [c_CW-1:0]         c_MAX_CNT = c_CW'(MAX_LEN);
  localparam logic signed [PW-1:0]    c_POS_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0]    c_NEG_MAX = {1'b1, {(PW-1){1'b0}}};

  logic w_en;
  assign w_en     = ~(out_valid & ~out_ready);
  assign in_ready = w_en;

  // ---------------- S1: pre-adder and operand register ----------------
  logic signed [BW:0] w_pre;

  generate
    if (PRE_EN != 0) begin : g_pre_add
      always_comb begin
        if (in_pre_sub)
          w_pre = {in_d[BW-1], in_d} - {in_b[BW-1], in_b};
        else
          w_pre = {in_d[BW-1], in_d} + {in_b[BW-1], in_b};
      end
    end else begin : g_pre_bypass
      always_comb w_pre = {in_b[BW-1], in_b};
    end
  endgenerate

  logic                r_s1_valid;
  logic signed [AW-1:0] r_s1_a;
  logic signed [BW:0]   r_s1_pre;
  logic                r_s1_acc_sub;
  logic                r_s1_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_pre     <= '0;
      r_s1_acc_sub <= 1'b0;
      r_s1_last    <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a       <= in_a;
        r_s1_pre     <= w_pre;
        r_s1_acc_sub <= in_acc_sub;
        r_s1_last    <= in_last;
      end
    end
  end

  // ---------------- S2: multiplier ----------------
  logic signed [c_MW-1:0] w_prod;
  logic signed [PW-1:0]   w_prod_ext;
  assign w_prod     = c_MW'(r_s1_a) * c_MW'(r_s1_pre);
  assign w_prod_ext = PW'(w_prod);

  logic                 w_m_valid;
  logic signed [PW-1:0] w_m;
  logic                 w_m_acc_sub;
  logic                 w_m_last;

  generate
    if (MREG != 0) begin : g_mreg
      logic                 r_s2_valid;
      logic signed [PW-1:0] r_s2_m;
      logic                 r_s2_acc_sub;
      logic                 r_s2_last;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_valid   <= 1'b0;
          r_s2_m       <= '0;
          r_s2_acc_sub <= 1'b0;
          r_s2_last    <= 1'b0;
        end else if (w_en) begin
          r_s2_valid   <= r_s1_valid;
          r_s2_m       <= w_prod_ext;
          r_s2_acc_sub <= r_s1_acc_sub;
          r_s2_last    <= r_s1_last;
        end
      end

      assign w_m_valid   = r_s2_valid;
      assign w_m         = r_s2_m;
      assign w_m_acc_sub = r_s2_acc_sub;
      assign w_m_last    = r_s2_last;
    end else begin : g_mcomb
      assign w_m_valid   = r_s1_valid;
      assign w_m         = w_prod_ext;
      assign w_m_acc_sub = r_s1_acc_sub;
      assign w_m_last    = r_s1_last;
    end
  endgenerate

  // ---------------- S3: accumulator and frame close ----------------
  logic signed [PW-1:0] r_acc;
  logic [c_CW-1:0]      r_count;
  logic                 r_ovf;

  logic signed [PW-1:0] w_base;
  logic signed [PW:0]   w_sum;
  logic                 w_sum_ovf;
  logic signed [PW-1:0] w_res;
  logic [c_CW-1:0]      w_count_nxt;
  logic                 w_frame_end;
  logic                 w_s3_fire;
  logic                 w_s3_done;

  always_comb begin
    w_base = (r_count == '0) ? '0 : r_acc;
    if (w_m_acc_sub)
      w_sum = {w_base[PW-1], w_base} - {w_m[PW-1], w_m};
    else
      w_sum = {w_base[PW-1], w_base} + {w_m[PW-1], w_m};
    // Top two bits disagree exactly when the sum no longer fits in PW bits.
    w_sum_ovf = w_sum[PW] ^ w_sum[PW-1];
    w_res     = w_sum[PW-1:0];
    if (w_sum_ovf && (SAT != 0))
      w_res = w_sum[PW] ? c_NEG_MAX : c_POS_MAX;
    w_count_nxt = r_count + c_CW'(1);
    w_frame_end = w_m_last | (w_count_nxt == c_MAX_CNT);
    w_s3_fire   = w_en & w_m_valid;
    w_s3_done   = w_s3_fire & w_frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      if (w_s3_done) begin
        r_acc     <= '0;
        r_count   <= '0;
        r_ovf     <= 1'b0;
        out_valid <= 1'b1;
        out_p     <= w_res;
        out_count <= w_count_nxt;
        out_ovf   <= r_ovf | w_sum_ovf;
        out_trunc <= ~w_m_last;
      end else begin
        if (w_s3_fire) begin
          r_acc   <= w_res;
          r_count <= w_count_nxt;
          r_ovf   <= r_ovf | w_sum_ovf;
        end
        if (out_ready)
          out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_stream.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for dsp_mac_stream: directed frame vectors applied to several
// parameterisations sharing one stimulus stream, plus multi-cycle sequences.
module tb_dsp_mac_stream;

  typedef logic signed [63:0] val_t;

  typedef struct {
    val_t p;
    val_t cnt;
    val_t ovf;
    val_t trunc;
  } res_t;

  typedef struct {
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic signed [17:0] d;
    logic               ps;
    logic               as;
    int                 n;
    val_t               exp_p;
    val_t               exp_cnt;
    val_t               exp_z;
    val_t               exp_s;
    val_t               exp_s_ovf;
    val_t               exp_w;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_pre_sub, in_acc_sub, in_last, out_ready;
  logic signed [17:0] in_a, in_b, in_d;

  // default build
  logic m_in_ready, m_out_valid, m_out_ovf, m_out_trunc;
  logic signed [47:0] m_out_p;
  logic [10:0] m_out_count;
  // MREG=0, PRE_EN=0
  logic z_in_ready, z_out_valid, z_out_ovf, z_out_trunc;
  logic signed [47:0] z_out_p;
  logic [10:0] z_out_count;
  // PW=40 saturating
  logic s_in_ready, s_out_valid, s_out_ovf, s_out_trunc;
  logic signed [39:0] s_out_p;
  logic [10:0] s_out_count;
  // PW=40 wrapping
  logic w_in_ready, w_out_valid, w_out_ovf, w_out_trunc;
  logic signed [39:0] w_out_p;
  logic [10:0] w_out_count;
  // MAX_LEN=4
  logic t_in_ready, t_out_valid, t_out_ovf, t_out_trunc;
  logic signed [47:0] t_out_p;
  logic [2:0] t_out_count;

  dsp_mac_stream dut_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_pre_sub(in_pre_sub),
    .in_acc_sub(in_acc_sub), .in_last(in_last), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_p(m_out_p), .out_count(m_out_count),
    .out_ovf(m_out_ovf), .out_trunc(m_out_trunc));

  dsp_mac_stream #(.MREG(0), .PRE_EN(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_pre_sub(in_pre_sub),
    .in_acc_sub(in_acc_sub), .in_last(in_last), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_p(z_out_p), .out_count(z_out_count),
    .out_ovf(z_out_ovf), .out_trunc(z_out_trunc));

  dsp_mac_stream #(.PW(40), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_pre_sub(in_pre_sub),
    .in_acc_sub(in_acc_sub), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_p(s_out_p), .out_count(s_out_count),
    .out_ovf(s_out_ovf), .out_trunc(s_out_trunc));

  dsp_mac_stream #(.PW(40), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_pre_sub(in_pre_sub),
    .in_acc_sub(in_acc_sub), .in_last(in_last), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_p(w_out_p), .out_count(w_out_count),
    .out_ovf(w_out_ovf), .out_trunc(w_out_trunc));

  dsp_mac_stream #(.MAX_LEN(4)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_pre_sub(in_pre_sub),
    .in_acc_sub(in_acc_sub), .in_last(in_last), .out_valid(t_out_valid),
    .out_ready(out_ready), .out_p(t_out_p), .out_count(t_out_count),
    .out_ovf(t_out_ovf), .out_trunc(t_out_trunc));

  res_t q_m[$], q_z[$], q_s[$], q_w[$], q_t[$];

  // Collect every completed output handshake per instance.
  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (m_out_valid) q_m.push_back('{val_t'(m_out_p), val_t'(m_out_count), val_t'(m_out_ovf), val_t'(m_out_trunc)});
      if (z_out_valid) q_z.push_back('{val_t'(z_out_p), val_t'(z_out_count), val_t'(z_out_ovf), val_t'(z_out_trunc)});
      if (s_out_valid) q_s.push_back('{val_t'(s_out_p), val_t'(s_out_count), val_t'(s_out_ovf), val_t'(s_out_trunc)});
      if (w_out_valid) q_w.push_back('{val_t'(w_out_p), val_t'(w_out_count), val_t'(w_out_ovf), val_t'(w_out_trunc)});
      if (t_out_valid) q_t.push_back('{val_t'(t_out_p), val_t'(t_out_count), val_t'(t_out_ovf), val_t'(t_out_trunc)});
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues;
    q_m.delete(); q_z.delete(); q_s.delete(); q_w.delete(); q_t.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic send_frame(input logic signed [17:0] a, input logic signed [17:0] b,
                            input logic signed [17:0] d, input logic ps, input logic as,
                            input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      in_valid   = 1'b1;
      in_a       = a;
      in_b       = b;
      in_d       = d;
      in_pre_sub = ps;
      in_acc_sub = as;
      in_last    = with_last && (i == n - 1);
      guard = 0;
      while (!m_in_ready && guard < 50) begin
        tick;
        guard++;
      end
      if (!m_in_ready) fail_now("in_ready_wait");
      tick;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_out_valid && lat < 20) begin
      tick;
      lat++;
    end
    if (!m_out_valid) fail_now("out_valid_wait");
  endtask

  task automatic check_res(input string name, input res_t q[$], input val_t p, input val_t cnt,
                           input val_t ovf, input val_t trunc, input int idx);
    if (q.size() > idx) begin
      check({name, "_p"}, q[idx].p, p);
      check({name, "_count"}, q[idx].cnt, cnt);
      check({name, "_ovf"}, q[idx].ovf, ovf);
      check({name, "_trunc"}, q[idx].trunc, trunc);
    end else begin
      fail_now({name, "_missing"});
    end
  endtask

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    vecs[0] = '{18'sd3, 18'sd2, 18'sd5, 1'b0, 1'b0, 4,
                64'sd84, 64'sd4, 64'sd24, 64'sd84, 64'sd0, 64'sd84};
    vecs[1] = '{-18'sd7, 18'sd4, 18'sd1, 1'b1, 1'b1, 1,
                -64'sd21, 64'sd1, 64'sd28, -64'sd21, 64'sd0, -64'sd21};
    vecs[2] = '{-18'sd100, 18'sd50, -18'sd20, 1'b0, 1'b0, 3,
                -64'sd9000, 64'sd3, -64'sd15000, -64'sd9000, 64'sd0, -64'sd9000};
    vecs[3] = '{18'sd1000, -18'sd300, 18'sd200, 1'b1, 1'b0, 2,
                64'sd1000000, 64'sd2, -64'sd600000, 64'sd1000000, 64'sd0, 64'sd1000000};
    vecs[4] = '{18'sh20000, 18'sh20000, 18'sh20000, 1'b0, 1'b0, 1,
                64'sd34359738368, 64'sd1, 64'sd17179869184, 64'sd34359738368, 64'sd0, 64'sd34359738368};
    vecs[5] = '{18'sd131071, 18'sd131071, 18'sd131071, 1'b0, 1'b0, 17,
                64'sd584106639394, 64'sd17, 64'sd292053319697, 64'sd549755813887, 64'sd1, -64'sd515404988382};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_d = '0; in_pre_sub = 1'b0; in_acc_sub = 1'b0;
    tick;
    tick;
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_p", m_out_p, 0);
    check("rst_out_count", m_out_count, 0);
    check("rst_out_ovf", m_out_ovf, 0);
    check("rst_out_trunc", m_out_trunc, 0);
    check("rst_in_ready", m_in_ready, 1);
    rst_n = 1'b1;

    // Table-driven frames across all parameterisations
    for (int i = 0; i < 6; i++) begin
      clear_queues();
      send_frame(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ps, vecs[i].as, vecs[i].n, 1'b1);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, 2);
      repeat (4) tick;
      check($sformatf("v%0d_main_nres", i), q_m.size(), 1);
      check_res($sformatf("v%0d_main", i), q_m, vecs[i].exp_p, vecs[i].exp_cnt, 0, 0, 0);
      if (q_z.size() > 0) check($sformatf("v%0d_m0_p", i), q_z[0].p, vecs[i].exp_z);
      else fail_now($sformatf("v%0d_m0_missing", i));
      if (q_s.size() > 0) begin
        check($sformatf("v%0d_sat_p", i), q_s[0].p, vecs[i].exp_s);
        check($sformatf("v%0d_sat_ovf", i), q_s[0].ovf, vecs[i].exp_s_ovf);
      end else fail_now($sformatf("v%0d_sat_missing", i));
      if (q_w.size() > 0) begin
        check($sformatf("v%0d_wrap_p", i), q_w[0].p, vecs[i].exp_w);
        check($sformatf("v%0d_wrap_ovf", i), q_w[0].ovf, vecs[i].exp_s_ovf);
      end else fail_now($sformatf("v%0d_wrap_missing", i));
    end

    // Backpressure: two 1-sample frames with the sink stalled
    do_reset();
    out_ready = 1'b0;
    send_frame(18'sd2, 18'sd1, 18'sd1, 1'b0, 1'b0, 1, 1'b1);
    send_frame(18'sd3, 18'sd1, 18'sd1, 1'b0, 1'b0, 1, 1'b1);
    wait_valid(lat);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_hold%0d_in_ready", c), m_in_ready, 0);
      check($sformatf("bp_hold%0d_valid", c), m_out_valid, 1);
      check($sformatf("bp_hold%0d_p", c), m_out_p, 4);
      check($sformatf("bp_hold%0d_count", c), m_out_count, 1);
      tick;
    end
    check("bp_no_early_handshake", q_m.size(), 0);
    out_ready = 1'b1;
    tick;
    check("bp_reload_valid", m_out_valid, 1);
    check("bp_reload_p", m_out_p, 6);
    tick;
    check("bp_drained_valid", m_out_valid, 0);
    repeat (3) tick;
    check("bp_nres", q_m.size(), 2);
    check_res("bp_first", q_m, 4, 1, 0, 0, 0);
    check_res("bp_second", q_m, 6, 1, 0, 0, 1);

    // Frame-length guard with MAX_LEN=4
    do_reset();
    send_frame(18'sd1, 18'sd0, 18'sd1, 1'b0, 1'b0, 6, 1'b1);
    repeat (8) tick;
    check("trunc_nres", q_t.size(), 2);
    check_res("trunc_first", q_t, 4, 4, 0, 1, 0);
    check_res("trunc_second", q_t, 2, 2, 0, 0, 1);
    check_res("trunc_main", q_m, 6, 6, 0, 0, 0);

    // Reset in the middle of a frame discards the partial sum
    do_reset();
    send_frame(18'sd5, 18'sd0, 18'sd5, 1'b0, 1'b0, 2, 1'b0);
    rst_n = 1'b0;
    tick;
    check("midrst_out_valid", m_out_valid, 0);
    rst_n = 1'b1;
    clear_queues();
    send_frame(18'sd1, 18'sd0, 18'sd1, 1'b0, 1'b0, 1, 1'b1);
    wait_valid(lat);
    repeat (3) tick;
    check("midrst_nres", q_m.size(), 1);
    check_res("midrst_frame", q_m, 1, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
